// File: rtl/tetris_input_pkg.sv
// Shared move indices, arbiter state encodings and default timing constants
// for the Tetris button-to-engine input path.
package tetris_input_pkg;

    localparam int unsigned MOVE_LEFT   = 0;
    localparam int unsigned MOVE_RIGHT  = 1;
    localparam int unsigned MOVE_ROTATE = 2;
    localparam int unsigned MOVE_DROP   = 3;
    localparam int unsigned NumMoves    = 4;

    localparam logic [23:0] DefTimeoutCycles = 24'd1_000_000;
    localparam logic [23:0] DefRepeatDelay   = 24'd10_000_000;
    localparam logic [23:0] DefRepeatRate    = 24'd2_500_000;
    localparam logic [3:0]  DefRepeatMask    = 4'b1011;

    // One-hot so the state register doubles as the debug LED pattern.
    typedef enum logic [3:0] {
        StIdle  = 4'b0001,
        StIssue = 4'b0010,
        StWait  = 4'b0100,
        StAck   = 4'b1000
    } arb_state_e;

    function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
        return {oh[3] | oh[2], oh[3] | oh[1]};
    endfunction

endpackage

// File: rtl/move_arbiter_if.sv
// Move request/grant bundle between the button controllers, the arbiter and
// the piece-motion engine.
interface move_arbiter_if;

    logic [3:0] iReq;
    logic [3:0] iHeld;
    logic       iEngineReady;
    logic       iMoveDone;
    logic [3:0] oMove;
    logic       oMoveValid;
    logic [3:0] oAck;
    logic       oBusy;
    logic       oTimeout;
    logic [3:0] LEDs;

    modport slave (
        input  iReq, iHeld, iEngineReady, iMoveDone,
        output oMove, oMoveValid, oAck, oBusy, oTimeout, LEDs
    );

    modport master (
        output iReq, iHeld, iEngineReady, iMoveDone,
        input  oMove, oMoveValid, oAck, oBusy, oTimeout, LEDs
    );

endinterface

// File: rtl/move_rr_pick.sv
// Combinational 4-way round-robin picker: search starts one past last_i and
// wraps 3 -> 0; output is the one-hot winner (zero when nothing requests).
module move_rr_pick
    import tetris_input_pkg::*;
(
    input  logic [3:0] req_i,
    input  logic [1:0] last_i,
    output logic [3:0] win_o
);

    logic [1:0] idx;
    logic       found;

    always_comb begin
        win_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= int'(NumMoves); i++) begin
            idx = last_i + 2'(i);
            if (!found && req_i[idx]) begin
                win_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/move_arbiter.sv
// Round-robin arbiter from the four button controllers onto the engine move port.
// Optional hold-to-repeat tracker enabled by defining MOVE_AUTOREPEAT_EN.
module move_arbiter
    import tetris_input_pkg::*;
#(
    parameter logic [23:0] TIMEOUT_CYCLES = DefTimeoutCycles,
    parameter logic [23:0] REPEAT_DELAY   = DefRepeatDelay,
    parameter logic [23:0] REPEAT_RATE    = DefRepeatRate,
    parameter logic [3:0]  REPEAT_MASK    = DefRepeatMask
) (
    input  logic           clk,
    input  logic           iReset,
    move_arbiter_if.slave  bus
);

    arb_state_e  state_q, state_d;
    logic [3:0]  grant_q, grant_d;
    logic [1:0]  last_grant_q, last_grant_d;
    logic [3:0]  ack_mask_q, ack_mask_d;
    logic [23:0] wd_q, wd_d;
    logic        timeout_q, timeout_d;
    logic [3:0]  rpt_req;
    logic [3:0]  eff_req;
    logic [3:0]  win;

    // The just-acknowledged requester is blocked for one IDLE cycle in case its
    // button has not yet dropped oSignal.
    assign eff_req = (bus.iReq | rpt_req) & ~ack_mask_q;

    move_rr_pick u_pick (
        .req_i  (eff_req),
        .last_i (last_grant_q),
        .win_o  (win)
    );

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        ack_mask_d   = '0;
        wd_d         = '0;
        timeout_d    = timeout_q;
        unique case (state_q)
            StIdle: begin
                if ((eff_req != '0) && bus.iEngineReady) begin
                    grant_d = win;
                    state_d = StIssue;
                end
            end
            StIssue: state_d = StWait;
            StWait: begin
                if (bus.iMoveDone) begin
                    state_d = StAck;
                end else if (wd_q >= TIMEOUT_CYCLES - 24'd1) begin
                    timeout_d = 1'b1;
                    state_d   = StAck;
                end else begin
                    wd_d = (wd_q == '1) ? wd_q : wd_q + 24'd1;
                end
            end
            StAck: begin
                last_grant_d = onehot_to_idx(grant_q);
                ack_mask_d   = grant_q;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (iReset) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            last_grant_q <= 2'd3;
            ack_mask_q   <= '0;
            wd_q         <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            ack_mask_q   <= ack_mask_d;
            wd_q         <= wd_d;
            timeout_q    <= timeout_d;
        end
    end

    assign bus.oMove      = ((state_q == StIssue) || (state_q == StWait)) ? grant_q : '0;
    assign bus.oMoveValid = (state_q == StIssue);
    assign bus.oAck       = (state_q == StAck) ? grant_q : '0;
    assign bus.oBusy      = (state_q != StIdle);
    assign bus.oTimeout   = timeout_q;
    assign bus.LEDs       = state_q;

`ifdef MOVE_AUTOREPEAT_EN
    logic        rpt_armed_q, rpt_armed_d;
    logic [1:0]  rpt_idx_q, rpt_idx_d;
    logic [23:0] rpt_cnt_q, rpt_cnt_d;
    logic [3:0]  rpt_req_q, rpt_req_d;
    logic [1:0]  ack_idx;

    assign ack_idx = onehot_to_idx(grant_q);

    always_comb begin
        rpt_armed_d = rpt_armed_q;
        rpt_idx_d   = rpt_idx_q;
        rpt_cnt_d   = (rpt_cnt_q != '0) ? rpt_cnt_q - 24'd1 : '0;
        rpt_req_d   = rpt_req_q;
        if (state_q == StAck) begin
            if (REPEAT_MASK[ack_idx] && bus.iHeld[ack_idx]) begin
                // An acknowledged repeat switches to the faster repeat rate.
                rpt_armed_d = 1'b1;
                rpt_idx_d   = ack_idx;
                rpt_cnt_d   = (rpt_armed_q && (rpt_idx_q == ack_idx) && rpt_req_q[ack_idx])
                              ? REPEAT_RATE : REPEAT_DELAY;
                rpt_req_d   = '0;
            end else begin
                rpt_armed_d = 1'b0;
                rpt_cnt_d   = '0;
                rpt_req_d   = '0;
            end
        end else if (rpt_armed_q && !bus.iHeld[rpt_idx_q]) begin
            rpt_armed_d = 1'b0;
            rpt_cnt_d   = '0;
            rpt_req_d   = '0;
        end else if (rpt_armed_q && (rpt_cnt_q == '0)) begin
            rpt_req_d[rpt_idx_q] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (iReset) begin
            rpt_armed_q <= 1'b0;
            rpt_idx_q   <= '0;
            rpt_cnt_q   <= '0;
            rpt_req_q   <= '0;
        end else begin
            rpt_armed_q <= rpt_armed_d;
            rpt_idx_q   <= rpt_idx_d;
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_req_q   <= rpt_req_d;
        end
    end

    assign rpt_req = rpt_req_q;
`else
    logic unused_rpt;
    assign unused_rpt = ^{REPEAT_DELAY, REPEAT_RATE, REPEAT_MASK, bus.iHeld};
    assign rpt_req    = '0;
`endif

endmodule

// File: tb/tb_move_arbiter.sv
// Directed bench for move_arbiter with a transaction-level reference model
// checked every cycle, plus literal expectations for each scenario.
module tb_move_arbiter;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic iReset;
    int   n_vec = 0;
    int   n_err = 0;

    move_arbiter_if bus ();

    move_arbiter #(
        .TIMEOUT_CYCLES (24'd16),
        .REPEAT_DELAY   (24'd20),
        .REPEAT_RATE    (24'd5)
    ) dut (
        .clk    (clk),
        .iReset (iReset),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: m_g is the granted requester (-1 when idle), m_t counts
    // cycles since the grant (1 = strobe cycle), m_ack marks the acknowledge cycle.
    int         m_g = -1, m_t = 0, m_last = 3, m_mask = -1, m_k;
    bit         m_ack = 0, m_to = 0, m_on = 0;
    logic [3:0] m_r;

    always @(posedge clk) begin
        if (iReset) begin
            m_g = -1; m_t = 0; m_last = 3; m_mask = -1; m_ack = 0; m_to = 0;
        end else if (m_g < 0) begin
            m_r = bus.iReq;
            if (m_mask >= 0) m_r[m_mask] = 1'b0;
            m_mask = -1;
            if (m_r != 4'b0 && bus.iEngineReady) begin
                for (int i = 1; i <= 4; i++) begin
                    m_k = (m_last + i) % 4;
                    if (m_g < 0 && m_r[m_k]) m_g = m_k;
                end
                m_t = 1;
            end
        end else if (m_ack) begin
            m_last = m_g; m_mask = m_g; m_g = -1; m_ack = 0;
        end else if (m_t == 1) begin
            m_t = 2;
        end else if (bus.iMoveDone) begin
            m_ack = 1;
        end else if (m_t - 2 == TO - 1) begin
            m_ack = 1; m_to = 1;
        end else begin
            m_t++;
        end
    end

    always @(posedge clk) begin
        #1;
        if (m_on) begin
            chk("mdl_move", bus.oMove, (m_g >= 0 && !m_ack) ? 4'(1 << m_g) : 4'b0);
            chk("mdl_valid", bus.oMoveValid, (m_g >= 0 && !m_ack && m_t == 1));
            chk("mdl_ack", bus.oAck, (m_g >= 0 && m_ack) ? 4'(1 << m_g) : 4'b0);
            chk("mdl_busy", bus.oBusy, m_g >= 0);
            chk("mdl_timeout", bus.oTimeout, m_to);
            chk("mdl_leds", bus.LEDs, (m_g < 0) ? 4'b0001 : m_ack ? 4'b1000 :
                                      (m_t == 1) ? 4'b0010 : 4'b0100);
        end
    end

    task automatic do_reset();
        iReset = 1'b1; bus.iReq = '0; bus.iHeld = '0; bus.iMoveDone = 1'b0;
        repeat (2) @(negedge clk);
        iReset = 1'b0;
        @(negedge clk);
    endtask

    // Leaves the caller at the negedge of the strobe cycle.
    task automatic wait_valid(input string nm);
        int n = 0;
        while (bus.oMoveValid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(nm, n < 40, 1'b1);
    endtask

    // From the strobe cycle: engine finishes two cycles later; ends in ACK.
    task automatic complete(input string nm, input logic [3:0] exp_ack);
        @(negedge clk);
        @(negedge clk);
        bus.iMoveDone = 1'b1;
        @(negedge clk);
        bus.iMoveDone = 1'b0;
        chk(nm, bus.oAck, exp_ack);
    endtask

    logic [3:0] got_order [5];
    logic [3:0] exp_order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    int cnt, n, t_ack, t_val;

    initial begin
        iReset = 1'b1; bus.iReq = '0; bus.iHeld = '0;
        bus.iEngineReady = 1'b0; bus.iMoveDone = 1'b0;
        repeat (3) @(negedge clk);
        iReset = 1'b0;
        m_on = 1'b1;
        @(negedge clk);
        chk("rst_leds", bus.LEDs, 4'b0001);
        chk("rst_busy", bus.oBusy, 1'b0);
        chk("rst_timeout", bus.oTimeout, 1'b0);
        chk("rst_move", bus.oMove, 4'b0000);
        chk("rst_ack", bus.oAck, 4'b0000);

        // Single rotate request, done on the second WAIT cycle.
        bus.iReq = 4'b0100; bus.iEngineReady = 1'b1;
        @(negedge clk);
        chk("t1_valid", bus.oMoveValid, 1'b1);
        chk("t1_move", bus.oMove, 4'b0100);
        chk("t1_leds_issue", bus.LEDs, 4'b0010);
        @(negedge clk);
        chk("t1_wait_valid", bus.oMoveValid, 1'b0);
        chk("t1_wait_move", bus.oMove, 4'b0100);
        @(negedge clk);
        bus.iMoveDone = 1'b1;
        @(negedge clk);
        bus.iMoveDone = 1'b0;
        chk("t1_ack", bus.oAck, 4'b0100);
        @(negedge clk);
        chk("t1_idle_ack_low", bus.oAck, 4'b0000);
        @(negedge clk);
        chk("t1_masked_no_reissue", bus.LEDs, 4'b0001);
        bus.iReq = '0;

        // All four held: round-robin order from reset.
        do_reset();
        bus.iReq = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_valid("t2_wait_issue");
            got_order[g] = bus.oMove;
            complete("t2_ack", got_order[g]);
        end
        bus.iReq = '0;
        for (int g = 0; g < 5; g++) chk($sformatf("t2_order%0d", g), got_order[g], exp_order[g]);

        // Engine not ready blocks issue; then no done -> watchdog.
        do_reset();
        bus.iEngineReady = 1'b0; bus.iReq = 4'b0001;
        cnt = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus.oMoveValid) cnt++;
        end
        chk("t3_no_issue_unready", cnt, 0);
        bus.iEngineReady = 1'b1;
        @(negedge clk);
        chk("t3_issue_on_ready", bus.oMoveValid, 1'b1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.oAck !== 4'b0001 && n < 40);
        chk("t4_ack_after_16_wait", n, 17);
        chk("t4_timeout_set", bus.oTimeout, 1'b1);
        bus.iReq = '0;
        repeat (5) @(negedge clk);
        chk("t4_timeout_sticky", bus.oTimeout, 1'b1);
        bus.iReq = 4'b0010;
        wait_valid("t4_second_issue");
        complete("t4_second_ack", 4'b0010);
        bus.iReq = '0;
        @(negedge clk);
        chk("t4_timeout_still", bus.oTimeout, 1'b1);

        // Reset during WAIT.
        do_reset();
        chk("t5_timeout_cleared", bus.oTimeout, 1'b0);
        bus.iReq = 4'b1000;
        wait_valid("t5_issue");
        @(negedge clk);
        iReset = 1'b1; bus.iReq = '0;
        @(negedge clk);
        iReset = 1'b0;
        chk("t5_ack", bus.oAck, 4'b0000);
        chk("t5_leds", bus.LEDs, 4'b0001);
        chk("t5_busy", bus.oBusy, 1'b0);
        chk("t5_move", bus.oMove, 4'b0000);
        chk("t5_valid", bus.oMoveValid, 1'b0);
        @(negedge clk);
        chk("t5_ack_next", bus.oAck, 4'b0000);

        // Done during ISSUE is ignored; done coinciding with expiry is a completion.
        bus.iReq = 4'b0001;
        wait_valid("t6_issue");
        bus.iReq = '0; bus.iMoveDone = 1'b1;
        @(negedge clk);
        bus.iMoveDone = 1'b0;
        chk("t6_issue_done_ignored", bus.LEDs, 4'b0100);
        n = 1;
        while (n < 16) begin
            @(negedge clk);
            n++;
        end
        bus.iMoveDone = 1'b1;
        @(negedge clk);
        bus.iMoveDone = 1'b0;
        chk("t6_ack_at_expiry", bus.oAck, 4'b0001);
        chk("t6_no_timeout", bus.oTimeout, 1'b0);
        @(negedge clk);

`ifndef MOVE_AUTOREPEAT_EN
        // iHeld has no effect without the repeat feature.
        bus.iHeld = 4'b1111; bus.iReq = 4'b0001;
        wait_valid("t7_issue");
        complete("t7_ack", 4'b0001);
        bus.iReq = '0;
        cnt = 0;
        repeat (60) begin
            @(negedge clk);
            if (bus.oMoveValid) cnt++;
        end
        chk("t7_held_ignored", cnt, 0);
`else
        m_on = 1'b0;
        do_reset();
        bus.iHeld = 4'b0001; bus.iReq = 4'b0001;
        wait_valid("t8_issue");
        complete("t8_ack", 4'b0001);
        t_ack = int'($time / 10);
        bus.iReq = '0;
        wait_valid("t8_first_repeat");
        t_val = int'($time / 10);
        chk($sformatf("t8_delay_gap_%0d", t_val - t_ack), (t_val - t_ack >= 18) &&
            (t_val - t_ack <= 26), 1'b1);
        chk("t8_repeat_move", bus.oMove, 4'b0001);
        complete("t8_repeat_ack", 4'b0001);
        t_ack = int'($time / 10);
        wait_valid("t8_second_repeat");
        t_val = int'($time / 10);
        chk($sformatf("t8_rate_gap_%0d", t_val - t_ack), (t_val - t_ack >= 4) &&
            (t_val - t_ack <= 12), 1'b1);
        complete("t8_second_ack", 4'b0001);
        bus.iHeld = '0;
        cnt = 0;
        repeat (60) begin
            @(negedge clk);
            if (bus.oMoveValid) cnt++;
        end
        chk("t8_release_stops", cnt, 0);
        do_reset();
        m_on = 1'b1;
`endif

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit expired");
    end

endmodule

// File: doc/move_arbiter.md
# move_arbiter

Arbitrates Tetris move requests from the four debounced button controllers (left, right, rotate, soft drop) onto the single game-engine move port. It grants one request at a time in round-robin order, issues a one-cycle move strobe, and waits for the engine to finish. It then returns a one-cycle acknowledge to the granted button's iOffSignal. It sits between the button instances and the piece-motion engine.

## Interface
- TIMEOUT_CYCLES, 24'd1_000_000 — maximum WAIT duration before forced acknowledge.
- REPEAT_DELAY, 24'd10_000_000 — hold time before the first auto-repeat (200 ms at 50 MHz).
- REPEAT_RATE, 24'd2_500_000 — interval between subsequent auto-repeats.
- REPEAT_MASK, 4'b1011 — requesters eligible for auto-repeat.
- clk  in  1  system clock.
- iReset  in  1  synchronous, active-high reset.
- iReq  in  4  button oSignal levels; bit 0 left, 1 right, 2 rotate, 3 drop.
- iHeld  in  4  raw debounced button levels, used only by auto-repeat.
- iEngineReady  in  1  engine can accept a move.
- iMoveDone  in  1  one-cycle pulse: engine finished the current move.
- oMove  out  4  one-hot granted move; valid during ISSUE and WAIT, 0 otherwise.
- oMoveValid  out  1  one-cycle move strobe.
- oAck  out  4  one-hot acknowledge pulse, wired to each button's iOffSignal.
- oBusy  out  1  state != IDLE.
- oTimeout  out  1  sticky flag; set on watchdog expiry, cleared only by reset.
- LEDs  out  4  one-hot current state, for debug.

## Operation
- States: IDLE, ISSUE, WAIT, ACK.
- IDLE: compute effective request = iReq | rptReq. If it is nonzero and iEngineReady=1, latch the round-robin winner into grant and go to ISSUE. Otherwise stay in IDLE.
- Round-robin search starts at lastGrant+1 and wraps 3→0. lastGrant resets to 3, so requester 0 wins first after reset.
- ISSUE: oMoveValid=1 and oMove=grant for exactly one cycle, then go to WAIT. iMoveDone is ignored in ISSUE.
- WAIT:
  - Watchdog counts cycles.
  - On iMoveDone, go to ACK.
  - When the count reaches TIMEOUT_CYCLES-1 without iMoveDone, set oTimeout and go to ACK.
- ACK: oAck[grant]=1 for one cycle, lastGrant←grant, go to IDLE.
- Request changes during ISSUE, WAIT or ACK are ignored; the grant stays latched until ACK.
- Reset outputs: oMove=0, oMoveValid=0, oAck=0, oBusy=0, oTimeout=0, LEDs=4'b0001, state=IDLE, lastGrant=3, all counters 0, rptReq=0.
- Reset mid-operation returns to IDLE immediately and issues no acknowledge. The buttons share iReset, so they reset too.
- Counters are 24 bits wide and saturate; they never wrap.

## Timing
- A request sampled in IDLE at cycle t produces oMoveValid at t+1.
- The earliest iMoveDone is at t+2, giving oAck at t+3 and IDLE at t+4.
- Button handshake: the button leaves its active states at t+4, so its oSignal is 0 when the arbiter re-enters IDLE and the same move is not reissued.
- As extra protection, requester grant is masked in the first IDLE cycle after ACK.
- Latency from IDLE to ACK is bounded by TIMEOUT_CYCLES+2.
- iMoveDone arriving in the same cycle as the watchdog expiry counts as completion; oTimeout is not set.

## Configuration
- MOVE_AUTOREPEAT_EN defined:
  - One repeat tracker is armed on ACK of requester k when REPEAT_MASK[k]=1 and iHeld[k]=1.
  - The tracker loads REPEAT_DELAY and decrements in every state.
  - At 0 with iHeld[k] still high, it sets rptReq[k].
  - When that repeat is acknowledged, the tracker reloads REPEAT_RATE.
  - iHeld[k]=0 clears the tracker and rptReq.
  - An acknowledge of a different requester clears the tracker and rptReq.
- MOVE_AUTOREPEAT_EN undefined: rptReq is constant 0, iHeld is ignored, and the port remains present.

## Structure
- Package tetris_input_pkg holds:
  - move indices MOVE_LEFT=0, MOVE_RIGHT=1, MOVE_ROTATE=2, MOVE_DROP=3;
  - state encodings;
  - default timing constants.
- Sub-module move_rr_pick: combinational 4-way round-robin picker. Inputs are the request vector and lastGrant; output is the one-hot winner. No state.

## Test plan
- Reset, then assert iReq=4'b0100 with iEngineReady=1 → oMoveValid at +1 with oMove=4'b0100. Pulse iMoveDone at +3 → oAck=4'b0100 at +4. No second issue follows.
- iReq=4'b1111 held, with each move completed 2 cycles after issue → grants appear in order 0,1,2,3,0.
- iEngineReady=0 with iReq=4'b0001 for 50 cycles → no oMoveValid. Raise ready → issue on the next cycle.
- TIMEOUT_CYCLES=16 with no iMoveDone → ACK at WAIT cycle 16 and oTimeout=1. oTimeout stays 1 until iReset.
- iReset asserted during WAIT → next cycle all outputs at reset values and oAck=0.
- MOVE_AUTOREPEAT_EN, with REPEAT_DELAY=20 and REPEAT_RATE=5: hold left (iHeld[0]=1) → repeat issues 20 cycles after the first ACK, then every 5 cycles plus handshake. Release → no further issues.
